// File: rtl/uart_loader.sv
// Serial boot loader: receives an 8N1 UART image (4-byte LE word count, then LE words)
// and presents each word with its byte address for the CPU to write into memory.
module uart_loader #(
  parameter int          CLK_FREQ  = 100_000_000,
  parameter int          BAUD      = 115_200,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 16384
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [31:0] uart_data,
  output logic [31:0] uart_addr,
  output logic        uart_wen,
  output logic        uart_done,
  output logic        frame_err,
  output logic [15:0] words_loaded
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int TW  = $clog2(CPB);
  localparam logic [TW-1:0] T_HALF = TW'(CPB / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(CPB - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_st_t;
  typedef enum logic [1:0] {LD_HDR, LD_BODY, LD_DONE} ld_st_t;

  // rx_d is one cycle behind rx_s so that IDLE can see a falling edge
  logic rx_m, rx_s, rx_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {rx_m, rx_s, rx_d} <= 3'b111;
    else        {rx_m, rx_s, rx_d} <= {rx, rx_m, rx_s};

  rx_st_t        rx_st, rx_nxt;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          byte_valid;
  logic [7:0]    rx_byte;
  logic          tick_half, tick_full;

  assign tick_half = (timer == T_HALF);
  assign tick_full = (timer == T_FULL);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rx_st <= RX_IDLE;
    else        rx_st <= rx_nxt;

  always_comb begin
    rx_nxt = rx_st;
    case (rx_st)
      RX_IDLE:  if (rx_d && !rx_s) rx_nxt = RX_START;
      RX_START: if (tick_half) rx_nxt = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick_full && bit_idx == 3'd7) rx_nxt = RX_STOP;
      RX_STOP:  if (tick_full) rx_nxt = rx_s ? RX_IDLE : RX_WAIT;
      RX_WAIT:  if (rx_s) rx_nxt = RX_IDLE;
      default:  rx_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      timer      <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      rx_byte    <= '0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      case (rx_st)
        RX_START: timer <= tick_half ? '0 : timer + 1'b1;
        RX_DATA: begin
          if (tick_full) begin
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            timer   <= '0;
          end else timer <= timer + 1'b1;
        end
        RX_STOP: begin
          if (tick_full) begin
            timer <= '0;
            if (rx_s) begin
              byte_valid <= 1'b1;
              rx_byte    <= shreg;
            end else frame_err <= 1'b1;
          end else timer <= timer + 1'b1;
        end
        default: begin
          timer   <= '0;
          bit_idx <= '0;
        end
      endcase
    end

  ld_st_t      ld_st, ld_nxt;
  logic [1:0]  byte_cnt;
  logic [31:0] asm_word, word_nxt;
  logic [15:0] n_eff, n_clamped;
  logic        hdr_last, word_last, img_last;

  // bytes shift in from the top so the first byte ends up in bits [7:0]
  assign word_nxt  = {rx_byte, asm_word[31:8]};
  assign n_clamped = (word_nxt > 32'(MAX_WORDS)) ? 16'(MAX_WORDS) : word_nxt[15:0];
  assign hdr_last  = (ld_st == LD_HDR)  && byte_valid && (byte_cnt == 2'd3);
  assign word_last = (ld_st == LD_BODY) && byte_valid && (byte_cnt == 2'd3);
  assign img_last  = (words_loaded + 16'd1 == n_eff);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ld_st <= LD_HDR;
    else        ld_st <= ld_nxt;

  always_comb begin
    ld_nxt = ld_st;
    case (ld_st)
      LD_HDR:  if (hdr_last) ld_nxt = (n_clamped == 16'd0) ? LD_DONE : LD_BODY;
      LD_BODY: if (word_last && img_last) ld_nxt = LD_DONE;
      default: ld_nxt = LD_DONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      byte_cnt     <= '0;
      asm_word     <= '0;
      n_eff        <= '0;
      uart_data    <= '0;
      uart_addr    <= BASE_ADDR;
      uart_wen     <= 1'b0;
      uart_done    <= 1'b0;
      words_loaded <= '0;
    end else begin
      uart_wen <= 1'b0;
      if (ld_st != LD_DONE && byte_valid) begin
        byte_cnt <= byte_cnt + 1'b1;
        asm_word <= word_nxt;
      end
      if (hdr_last) begin
        n_eff <= n_clamped;
        // empty image: done must follow the last header strobe directly
        if (n_clamped == 16'd0) uart_done <= 1'b1;
      end
      if (word_last) begin
        uart_data    <= word_nxt;
        uart_addr    <= BASE_ADDR + {14'd0, words_loaded, 2'b00};
        uart_wen     <= 1'b1;
        words_loaded <= words_loaded + 16'd1;
      end
      // entering DONE after a word lands one cycle after its wen pulse
      if (ld_st == LD_DONE) uart_done <= 1'b1;
    end

endmodule
